md_sched: RTL and testbench

//   Multiply/divide scheduler for the pipelined MIPS datapath. Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO

---
 rtl/md_sched.sv | 152 +++++++++++++++
 tb/tb_md_sched.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/md_sched.sv
// Multiply/divide scheduler: owns HI/LO, holds MULT/DIV for a fixed latency and drives busy.
// Define MD_FLUSH_EN to add the flush input that cancels in-flight or launching operations.
module md_sched #(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
`ifdef MD_FLUSH_EN
    input  logic        flush,
`endif
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;
    typedef enum logic [2:0] {
        OP_MULT  = 3'b000,
        OP_MULTU = 3'b001,
        OP_DIV   = 3'b010,
        OP_DIVU  = 3'b011,
        OP_MTHI  = 3'b100,
        OP_MTLO  = 3'b101
    } md_op_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [31:0]   hi_nx, lo_nx;
    logic [31:0]   hi_n, lo_n, hi_n_nx, lo_n_nx;
    logic          div0, div0_nx;
    logic          flush_i;
    md_op_t        op;

`ifdef MD_FLUSH_EN
    assign flush_i = flush;
`else
    assign flush_i = 1'b0;
`endif

    assign op   = md_op_t'(md_op);
    assign busy = (state != IDLE);

    // Arithmetic results, evaluated from the live operands and captured only on launch
    logic [63:0] prod_s, prod_u;
    logic [31:0] a_mag, b_mag, b_safe, q_mag, r_mag;
    logic [31:0] quo_s, rem_s, quo_u, rem_u;

    always_comb begin
        prod_u = {32'b0, rs_val} * {32'b0, rt_val};
        prod_s = {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val};
        a_mag  = rs_val[31] ? (~rs_val + 32'd1) : rs_val;
        b_mag  = rt_val[31] ? (~rt_val + 32'd1) : rt_val;
        b_safe = (rt_val == '0) ? 32'd1 : rt_val;
        if (b_mag == '0) begin
            q_mag = '0;
            r_mag = '0;
        end else begin
            q_mag = a_mag / b_mag;
            r_mag = a_mag % b_mag;
        end
        // Magnitude form makes 0x80000000 / -1 wrap to 0x80000000 with zero remainder
        quo_s = (rs_val[31] ^ rt_val[31]) ? (~q_mag + 32'd1) : q_mag;
        rem_s = rs_val[31] ? (~r_mag + 32'd1) : r_mag;
        quo_u = rs_val / b_safe;
        rem_u = rs_val % b_safe;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            hi    <= '0;
            lo    <= '0;
            hi_n  <= '0;
            lo_n  <= '0;
            div0  <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            hi    <= hi_nx;
            lo    <= lo_nx;
            hi_n  <= hi_n_nx;
            lo_n  <= lo_n_nx;
            div0  <= div0_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        hi_nx    = hi;
        lo_nx    = lo;
        hi_n_nx  = hi_n;
        lo_n_nx  = lo_n;
        div0_nx  = div0;
        done     = 1'b0;
        case (state)
            IDLE: begin
                if (start && !flush_i) begin
                    case (op)
                        OP_MULT, OP_MULTU: begin
                            state_nx = MUL;
                            cnt_nx   = CW'(MUL_CYCLES);
                            {hi_n_nx, lo_n_nx} = (op == OP_MULT) ? prod_s : prod_u;
                            div0_nx  = 1'b0;
                        end
                        OP_DIV, OP_DIVU: begin
                            state_nx = DIV;
                            cnt_nx   = CW'(DIV_CYCLES);
                            hi_n_nx  = (op == OP_DIV) ? rem_s : rem_u;
                            lo_n_nx  = (op == OP_DIV) ? quo_s : quo_u;
                            div0_nx  = (rt_val == '0);
                        end
                        OP_MTHI: hi_nx = rs_val;
                        OP_MTLO: lo_nx = rs_val;
                        default: ;
                    endcase
                end
            end
            MUL, DIV: begin
                if (flush_i) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else if (cnt == CW'(1)) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                    done     = 1'b1;
                    if (!div0) begin
                        hi_nx = hi_n;
                        lo_nx = lo_n;
                    end
                end else begin
                    cnt_nx = cnt - CW'(1);
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_md_sched.sv
// Directed bench for md_sched: latency, commit pulse, HI/LO results, reset abort and ignored starts.
module tb_md_sched;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  md_op = 3'b000;
    logic        flush = 1'b0;
    logic [31:0] rs_val = '0;
    logic [31:0] rt_val = '0;
    logic        busy, done;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    md_sched #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .md_op  (md_op),
`ifdef MD_FLUSH_EN
        .flush  (flush),
`endif
        .rs_val (rs_val),
        .rt_val (rt_val),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Called at a negedge; launches op, optionally injects a start at busy cycle inj_cycle,
    // returns at the first negedge with busy low.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int inj_cycle, input logic [2:0] inj_op,
                          output int cycles, output int dones);
        start  = 1'b1;
        md_op  = op;
        rs_val = a;
        rt_val = b;
        @(negedge clk);
        start  = 1'b0;
        rs_val = 32'hA5A5A5A5;
        rt_val = 32'h5A5A5A5A;
        cycles = 0;
        dones  = 0;
        while (busy && cycles < 40) begin
            cycles++;
            if (done) dones++;
            if (cycles == inj_cycle) begin
                start = 1'b1;
                md_op = inj_op;
            end
            @(negedge clk);
            start = 1'b0;
        end
    endtask

    task automatic move_to(input logic [2:0] op, input logic [31:0] v);
        start  = 1'b1;
        md_op  = op;
        rs_val = v;
        @(negedge clk);
        start  = 1'b0;
    endtask

    initial begin
        int cyc, dn;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_hi", hi, 32'h0);
        check("rst_lo", lo, 32'h0);

        run_op(3'b000, 32'hFFFFFFFE, 32'd3, 0, 3'b000, cyc, dn);
        check("mult_cycles", 32'(cyc), 32'd5);
        check("mult_done", 32'(dn), 32'd1);
        check("mult_hi", hi, 32'hFFFFFFFF);
        check("mult_lo", lo, 32'hFFFFFFFA);

        // Back-to-back launch, plus a MULT start during busy cycle 2 that must be ignored
        run_op(3'b011, 32'd100, 32'd7, 2, 3'b000, cyc, dn);
        check("divu_cycles", 32'(cyc), 32'd10);
        check("divu_done", 32'(dn), 32'd1);
        check("divu_hi", hi, 32'd2);
        check("divu_lo", lo, 32'd14);

        run_op(3'b010, 32'hFFFFFFF9, 32'd2, 0, 3'b000, cyc, dn);
        check("div_hi", hi, 32'hFFFFFFFF);
        check("div_lo", lo, 32'hFFFFFFFD);

        run_op(3'b010, 32'h80000000, 32'hFFFFFFFF, 0, 3'b000, cyc, dn);
        check("divovf_hi", hi, 32'h0);
        check("divovf_lo", lo, 32'h80000000);

        start = 1'b1; md_op = 3'b100; rs_val = 32'hDEADBEEF;
        @(negedge clk);
        check("mthi_busy", 32'(busy), 32'd0);
        check("mthi_hi", hi, 32'hDEADBEEF);
        check("mthi_lo", lo, 32'h80000000);
        md_op = 3'b101; rs_val = 32'h12345678;
        @(negedge clk);
        start = 1'b0;
        check("mtlo_busy", 32'(busy), 32'd0);
        check("mtlo_done", 32'(done), 32'd0);
        check("mtlo_hi", hi, 32'hDEADBEEF);
        check("mtlo_lo", lo, 32'h12345678);

        move_to(3'b100, 32'h11);
        move_to(3'b101, 32'h22);
        run_op(3'b010, 32'd5, 32'd0, 0, 3'b000, cyc, dn);
        check("div0_cycles", 32'(cyc), 32'd10);
        check("div0_done", 32'(dn), 32'd1);
        check("div0_hi", hi, 32'h11);
        check("div0_lo", lo, 32'h22);

        run_op(3'b110, 32'hCAFEF00D, 32'd1, 0, 3'b000, cyc, dn);
        check("undef_cycles", 32'(cyc), 32'd0);
        check("undef_hi", hi, 32'h11);
        check("undef_lo", lo, 32'h22);

        run_op(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 3'b000, cyc, dn);
        check("multu_cycles", 32'(cyc), 32'd5);
        check("multu_hi", hi, 32'hFFFFFFFE);
        check("multu_lo", lo, 32'h00000001);

        // Reset on busy cycle 3 aborts the operation and clears HI/LO
        start = 1'b1; md_op = 3'b001; rs_val = 32'hFFFFFFFF; rt_val = 32'hFFFFFFFF;
        @(negedge clk);
        start = 1'b0;
        check("abort_busy1", 32'(busy), 32'd1);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_hi", hi, 32'h0);
        check("abort_lo", lo, 32'h0);
        dn = 0;
        for (int i = 0; i < 8; i++) begin
            if (done || busy) dn++;
            @(negedge clk);
        end
        check("abort_quiet", 32'(dn), 32'd0);

`ifdef MD_FLUSH_EN
        move_to(3'b100, 32'h33);
        move_to(3'b101, 32'h44);
        start = 1'b1; md_op = 3'b011; rs_val = 32'd100; rt_val = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", 32'(busy), 32'd0);
        check("flush_hi", hi, 32'h33);
        check("flush_lo", lo, 32'h44);
        dn = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) dn++;
            @(negedge clk);
        end
        check("flush_nodone", 32'(dn), 32'd0);
        flush = 1'b1;
        move_to(3'b100, 32'h99);
        flush = 1'b0;
        check("flush_mthi", hi, 32'h33);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
